// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed hex display path.
//   nibble_t            : one hex digit as carried to the 7-segment decoder
//   ANODE_OFF           : all-ones digit-enable pattern, truncated at use
//   DEFAULT_REFRESH_DIV : clk cycles each digit stays selected
package display_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [63:0] ANODE_OFF           = '1;
    localparam int          DEFAULT_REFRESH_DIV = 50000;

endpackage

// File: rtl/scan_tick_gen.sv
// Refresh prescaler: counts 0 .. REFRESH_DIV-1 and wraps.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   oTick : high while the count sits at REFRESH_DIV-1 (one cycle per period)
module scan_tick_gen
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic oTick
);

    localparam int                CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] count;

    assign oTick = (count == LAST);

    // NOTE: sequential state is always assigned with <= so every register
    // samples its inputs from before the edge, regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= oTick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexes a NUM_DIGITS hex value onto one shared 7-segment decoder.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   value_in   : new display value, digit 0 in bits [3:0]
//   load       : one-cycle strobe capturing value_in (applied at next frame wrap)
//   blank_lz   : 1 = suppress leading zeros
//   oNibble    : nibble of the digit being scanned (to decoder)
//   oBlank     : 1 = force all segments off for this digit
//   oAnode     : active-low digit enables, one cycle behind oNibble/oBlank
//   oPending   : a loaded value waits for the next frame wrap
//   oFrame     : one-cycle pulse after each frame wrap
module digit_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output nibble_t                 oNibble,
    output logic                    oBlank,
    output logic [NUM_DIGITS-1:0]   oAnode,
    output logic                    oPending,
    output logic                    oFrame
);

    localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int                VAL_W    = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                  tick;
    logic                  wrap;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic [VAL_W-1:0]      display_reg;
    logic [VAL_W-1:0]      display_next;
    logic [VAL_W-1:0]      pending_reg;
    nibble_t               digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_mask;

    scan_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .oTick (tick)
    );

    // Index advance and the value the display register takes this edge.
    // oNibble/oBlank are computed from these "next" values so the first digit
    // of a frame already reflects a value swapped in at that same wrap.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wrap         = tick && (idx == LAST_IDX);
        idx_next     = idx;
        display_next = display_reg;
        if (tick) begin
            idx_next = wrap ? '0 : idx + IDX_W'(1);
        end
        if (wrap) begin
            if (load) begin
                display_next = value_in;
            end else if (oPending) begin
                display_next = pending_reg;
            end
        end
    end

    // Digit i is a leading zero when it and every more-significant digit are
    // zero; digit 0 is excluded so an all-zero value still shows "0".
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            digits[i]  = display_next[4*i +: 4];
            zero_run   = zero_run && (digits[i] == 4'h0);
            lz_mask[i] = zero_run && (i != 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            display_reg <= '0;
            pending_reg <= '0;
            oPending    <= 1'b0;
            oNibble     <= '0;
            oBlank      <= 1'b0;
            oAnode      <= NUM_DIGITS'(ANODE_OFF);
            oFrame      <= 1'b0;
        end else begin
            idx         <= idx_next;
            display_reg <= display_next;
            // A load coinciding with a wrap went straight into display_next,
            // so any older pending value is simply dropped.
            if (wrap) begin
                oPending <= 1'b0;
            end else if (load) begin
                pending_reg <= value_in;
                oPending    <= 1'b1;
            end
            oNibble <= digits[idx_next];
            oBlank  <= blank_lz && lz_mask[idx_next];
            // Uses the pre-edge idx: enables trail the nibble by one cycle to
            // line up with the decoder's output register.
            oAnode  <= ~(NUM_DIGITS'(1) << idx);
            oFrame  <= wrap;
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench for digit_scan_mux (NUM_DIGITS=4, REFRESH_DIV=4).
// The driver follows a fixed edge timeline and pushes the expected digit
// presentations; a monitor pops one entry each time oAnode changes.
module tb_digit_scan_mux;

    typedef struct {
        logic [3:0] anode;
        logic [3:0] nib;
        logic       blank;
        logic       pend;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  oNibble;
    logic        oBlank;
    logic [3:0]  oAnode;
    logic        oPending;
    logic        oFrame;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   ecount;

    digit_scan_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_in (value_in),
        .load     (load),
        .blank_lz (blank_lz),
        .oNibble  (oNibble),
        .oBlank   (oBlank),
        .oAnode   (oAnode),
        .oPending (oPending),
        .oFrame   (oFrame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; frame f, digit d appears on oAnode at edge 16f+4d+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_edge(input int n);
        while (ecount < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_at(input int n, input logic [15:0] v);
        wait_edge(n - 1);
        value_in = v;
        load     = 1'b1;
        wait_edge(n);
        load     = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] blank_mask,
                              input logic [3:0] pend_mask, input int count);
        exp_t e;
        for (int d = 0; d < count; d++) begin
            e.anode = ~(4'b0001 << d);
            e.nib   = v[d*4 +: 4];
            e.blank = blank_mask[d];
            e.pend  = pend_mask[d];
            sb.push_back(e);
        end
    endtask

    // Monitor: one comparison set per new digit enable.
    logic [3:0] prev_anode;
    logic [3:0] prev_nib;
    logic       prev_frame;
    logic       first;
    int         dwell;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_anode = 4'hF;
            first      = 1'b1;
            dwell      = 0;
        end else begin
            dwell++;
            if (oAnode != prev_anode) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_digit: got anode %b with no expectation queued (t=%0t)",
                             oAnode, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("anode",   32'(oAnode),   32'(e.anode));
                    check("nibble",  32'(oNibble),  32'(e.nib));
                    check("blank",   32'(oBlank),   32'(e.blank));
                    check("pending", 32'(oPending), 32'(e.pend));
                    if (!first) begin
                        check("nibble_lead", 32'(prev_nib), 32'(e.nib));
                        check("dwell", 32'(dwell), 32'd4);
                        if (e.anode == 4'b1110) begin
                            check("frame_pulse", 32'(prev_frame), 32'd1);
                            check("frame_width", 32'(oFrame), 32'd0);
                        end
                    end
                end
                first      = 1'b0;
                dwell      = 0;
                prev_anode = oAnode;
            end
        end
        prev_nib   = oNibble;
        prev_frame = oFrame;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        value_in = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_anode",   32'(oAnode),   32'hF);
        check("rst_nibble",  32'(oNibble),  32'h0);
        check("rst_blank",   32'(oBlank),   32'h0);
        check("rst_pending", 32'(oPending), 32'h0);
        check("rst_frame",   32'(oFrame),   32'h0);
        #2 rst_n = 1'b1;
        #1 check("anode_before_first_update", 32'(oAnode), 32'hF);

        // Frame 0: display 0, free running.
        push_frame(16'h0000, 4'b0000, 4'b0000, 4);

        // Frame 1: load 1A3F mid-frame; pending until the wrap.
        wait_edge(16);
        push_frame(16'h0000, 4'b0000, 4'b1110, 4);
        load_at(20, 16'h1A3F);

        // Frame 2: shows 1A3F; two loads, only the latest survives.
        wait_edge(32);
        push_frame(16'h1A3F, 4'b0000, 4'b1110, 4);
        load_at(36, 16'h1111);
        load_at(40, 16'h2222);

        // Frame 3: shows 2222; load 00B0 exactly on the wrap-tick cycle.
        wait_edge(48);
        push_frame(16'h2222, 4'b0000, 4'b0000, 4);
        load_at(64, 16'h00B0);
        check("pending_after_wrap_load", 32'(oPending), 32'h0);

        // Frame 4: shows 00B0 without blanking.
        push_frame(16'h00B0, 4'b0000, 4'b0000, 4);
        wait_edge(78);
        blank_lz = 1'b1;

        // Frame 5: 00B0 with leading-zero blanking; load 0000 mid-frame.
        wait_edge(80);
        push_frame(16'h00B0, 4'b1100, 4'b1110, 4);
        load_at(84, 16'h0000);

        // Frame 6: 0000 blanked; load 5555 then reset mid-scan.
        wait_edge(96);
        push_frame(16'h0000, 4'b1110, 4'b0010, 2);
        load_at(99, 16'h5555);
        wait_edge(102);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_anode",   32'(oAnode),   32'hF);
        check("async_rst_pending", 32'(oPending), 32'h0);
        check("async_rst_nibble",  32'(oNibble),  32'h0);
        check("async_rst_frame",   32'(oFrame),   32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check("anode_after_release", 32'(oAnode), 32'hF);
        check("sb_consumed_before_reset", 32'(sb.size()), 32'd0);

        // Restart at digit 0; the 5555 load must have been discarded.
        push_frame(16'h0000, 4'b1110, 4'b0000, 4);
        wait_edge(16);
        #5;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
